// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared state, requester ids and width defaults for the register file write-back arbiter
package regfile_wb_pkg;
    typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter, one-hot grant favouring the requester not granted last
module rr_arb2
    import regfile_wb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);
    always_comb begin
        grant[0] = valid0 && (!valid1 || last_grant == REQ_MEM);
        grant[1] = valid1 && (!valid0 || last_grant == REQ_ALU);
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: zero-fills the register file after reset, then round-robins ALU/load writes onto its single write port (REGFILE_WB_ZERO_REG_EN suppresses writes to register 0)
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic [AW-1:0] a3,
    output logic [DW-1:0] wd3,
    output logic          we3,
    output logic          init_done,
    output logic [CW-1:0] conflict_cnt
);
    state_t        state;
    logic [AW-1:0] cnt;
    logic          last_grant;
    logic [1:0]    grant;
    logic          run;
    logic          xfer;
    logic          wr_ok;
    logic [AW-1:0] win_rd;
    logic [DW-1:0] win_data;
    always_comb begin
        run       = state == RUN;
        alu_ready = run && (!mem_valid || last_grant == REQ_MEM);
        mem_ready = run && (!alu_valid || last_grant == REQ_ALU);
        xfer      = |grant;
        win_rd    = grant[1] ? mem_rd : alu_rd;
        win_data  = grant[1] ? mem_data : alu_data;
    end
`ifdef REGFILE_WB_ZERO_REG_EN
    assign wr_ok = win_rd != '0;
`else
    assign wr_ok = 1'b1;
`endif
    rr_arb2 u_arb (
        .valid0     (run && alu_valid),
        .valid1     (run && mem_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            cnt          <= '0;
            last_grant   <= REQ_ALU;
            we3          <= 1'b0;
            a3           <= '0;
            wd3          <= '0;
            init_done    <= 1'b0;
            conflict_cnt <= '0;
        end else if (!run) begin
            we3 <= 1'b1;
            a3  <= cnt;
            wd3 <= '0;
            cnt <= cnt + AW'(1);
            if (cnt == AW'(NREGS - 1)) begin
                state     <= RUN;
                init_done <= 1'b1;
            end
        end else begin
            we3 <= xfer && wr_ok;
            if (xfer) begin
                last_grant <= grant[1] ? REQ_MEM : REQ_ALU;
                if (wr_ok) begin
                    a3  <= win_rd;
                    wd3 <= win_data;
                end
            end
            if (alu_valid && mem_valid && !(&conflict_cnt))
                conflict_cnt <= conflict_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: random and directed stimulus checked every cycle against a behavioural model of the write-back rules
module tb_regfile_wb_arbiter;
    localparam int NREGS = 32, AW = 5, DW = 32, CW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0, mem_rd = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic alu_ready, mem_ready, we3, init_done;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic [CW-1:0] conflict_cnt;
    int compared = 0, mismatched = 0;
    int m_init_idx = 0, m_cc = 0;
    bit m_run = 0, m_done = 0, m_last = 0, m_we = 0;
    int m_a = 0;
    logic [DW-1:0] m_wd = '0;

    regfile_wb_arbiter #(.NREGS(NREGS), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .a3(a3), .wd3(wd3), .we3(we3), .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit av, input int ar, input logic [DW-1:0] ad,
                         input bit mv, input int mr, input logic [DW-1:0] md);
        alu_valid = av; alu_rd = AW'(ar); alu_data = ad;
        mem_valid = mv; mem_rd = AW'(mr); mem_data = md;
    endtask

    task automatic model_edge();
        int winner;
        if (rst) begin
            m_init_idx = 0; m_run = 0; m_done = 0; m_cc = 0; m_last = 0;
            m_we = 0; m_a = 0; m_wd = '0;
        end else if (!m_run) begin
            m_we = 1; m_a = m_init_idx; m_wd = '0;
            m_init_idx++;
            if (m_init_idx == NREGS) begin m_run = 1; m_done = 1; end
        end else begin
            winner = (alu_valid && mem_valid) ? (m_last ? 0 : 1) : alu_valid ? 0 : mem_valid ? 1 : -1;
            m_we = 0;
            if (winner >= 0) begin
                m_last = winner[0];
`ifdef REGFILE_WB_ZERO_REG_EN
                if ((winner == 1 ? int'(mem_rd) : int'(alu_rd)) != 0) begin
`else
                begin
`endif
                    m_we = 1;
                    m_a  = winner == 1 ? int'(mem_rd) : int'(alu_rd);
                    m_wd = winner == 1 ? mem_data : alu_data;
                end
            end
            if (alu_valid && mem_valid && m_cc < (1 << CW) - 1) m_cc++;
        end
    endtask

    task automatic tick();
        #1;
        chk("alu_ready", alu_ready, m_run && (!mem_valid || m_last));
        chk("mem_ready", mem_ready, m_run && (!alu_valid || !m_last));
        @(posedge clk);
        model_edge();
        #1;
        chk("we3", we3, m_we);
        chk("a3", a3, m_a);
        chk("wd3", wd3, m_wd);
        chk("init_done", init_done, m_done);
        chk("conflict_cnt", conflict_cnt, m_cc);
    endtask

    initial begin
        @(posedge clk); #1;
        tick(); tick();
        chk("rst_we3", we3, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_conflict", conflict_cnt, 0);
        rst = 1'b0;
        drive(1, 3, 32'h11, 1, 4, 32'h22);
        for (int i = 0; i < NREGS; i++) begin
            chk("init_alu_ready", alu_ready, 0);
            tick();
            chk("init_a3", a3, i);
            chk("init_we3", we3, 1);
            chk("init_wd3", wd3, 0);
        end
        chk("init_done_lit", init_done, 1);
        chk("init_conflict_lit", conflict_cnt, 0);
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        #1 chk("alu_only_ready", alu_ready, 1);
        tick();
        chk("alu_only_a3", a3, 5);
        chk("alu_only_wd3", wd3, 32'hDEADBEEF);
        chk("alu_only_we3", we3, 1);
        drive(1, 1, 32'hA1, 1, 2, 32'hB2);
        for (int k = 0; k < 4; k++) begin
            #1 chk("conf_mem_ready", mem_ready, k % 2 == 0);
            tick();
            chk("conf_a3", a3, k % 2 == 0 ? 2 : 1);
        end
        chk("conf_cnt4", conflict_cnt, 4);
        for (int n = 0; n < 600; n++) begin
            rst = $urandom_range(0, 59) == 0;
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom);
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < NREGS + 2; n++) tick();
        drive(1, 9, 32'h99, 1, 10, 32'hAA);
        tick();
        chk("pre_rst_we3", we3, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_we3", we3, 0);
        chk("mid_rst_conflict", conflict_cnt, 0);
        rst = 1'b0;
        tick();
        chk("restart_a3", a3, 0);
        chk("restart_we3", we3, 1);
        for (int n = 0; n < NREGS; n++) tick();
        drive(1, 0, 32'h7, 0, 0, 0);
        #1 chk("zero_ready", alu_ready, 1);
        tick();
`ifdef REGFILE_WB_ZERO_REG_EN
        chk("zero_we3", we3, 0);
`else
        chk("zero_a3", a3, 0);
        chk("zero_wd3", wd3, 7);
        chk("zero_we3", we3, 1);
`endif
        drive(1, 6, 32'h66, 1, 7, 32'h77);
        for (int n = 0; n < 65535 + 3; n++) tick();
        chk("sat_conflict", conflict_cnt, 16'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
